// File: rtl/fp32_divsqrt_issue_ctrl_if.sv
// Issue/writeback handshake bundle for the FP32 div/sqrt issue controller.
// master: FP issue stage + writeback stage side; slave: the controller.
interface fp32_divsqrt_issue_ctrl_if #(
  parameter int TAG_WIDTH = 7
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_lhs;
  logic [31:0]          in_rhs;
  logic                 in_is_divide;
  logic [2:0]           in_rm;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_result;
  logic [4:0]           out_fflags;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_lhs, in_rhs, in_is_divide, in_rm, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_fflags, out_tag
  );

  modport slave (
    input  in_valid, in_lhs, in_rhs, in_is_divide, in_rm, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_fflags, out_tag
  );
endinterface

// File: rtl/fp32_divsqrt_issue_ctrl.sv
// Issue/writeback controller in front of the FP32 iterative div/sqrt core.
// Small FIFO of tagged ops, one op in flight, in-order results, flush with
// drain of the non-abortable core.
// Optional macro FP_DIVSQRT_SPECIAL_BYPASS_EN: NaN/zero/inf operands (and
// sqrt of negatives) complete locally in IDLE without launching the core.
module fp32_divsqrt_issue_ctrl #(
  parameter int TAG_WIDTH   = 7,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  fp32_divsqrt_issue_ctrl_if.slave io,
  input  logic [2:0]  frm,
  input  logic        flush,
  output logic        core_req,
  output logic [31:0] core_lhs,
  output logic [31:0] core_rhs,
  output logic        core_is_divide,
  output logic [2:0]  core_round_mode,
  input  logic        core_finished,
  input  logic [31:0] core_result,
  input  logic [4:0]  core_fflags
);
  localparam int          AW       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = QUEUE_DEPTH[AW:0];

  typedef struct packed {
    logic [31:0]          lhs;
    logic [31:0]          rhs;
    logic                 is_div;
    logic [2:0]           rm;
    logic [TAG_WIDTH-1:0] tag;
  } op_t;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  op_t           mem [QUEUE_DEPTH];
  op_t           head, push_op, issued;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, push, pop;
  logic          slot_free, launch, bypass, capture;
  state_t        state, state_nxt;

  logic          byp_hit;
  logic [31:0]   byp_result;
  logic [4:0]    byp_fflags;

  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign io.in_ready = !full;
  assign push        = io.in_valid && !full && !flush;
  assign pop         = launch || bypass;
  assign head        = mem[rd_ptr];
  assign slot_free   = !io.out_valid || io.out_ready;

  // Dynamic rounding mode is resolved once, when the op enters the FIFO.
  assign push_op = '{lhs:    io.in_lhs,
                     rhs:    io.in_rhs,
                     is_div: io.in_is_divide,
                     rm:     (io.in_rm == 3'b111) ? frm : io.in_rm,
                     tag:    io.in_tag};

`ifdef FP_DIVSQRT_SPECIAL_BYPASS_EN
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Returns {hit, result, fflags} for operands the core need not see.
  function automatic logic [37:0] special_eval(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic        is_div);
    logic a_nan, b_nan, a_snan, b_snan, a_zero, b_zero, a_inf, b_inf, sgn;
    logic [37:0] r;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    a_snan = a_nan && !a[22];
    b_snan = b_nan && !b[22];
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    a_zero = (a[30:0] == '0);
    b_zero = (b[30:0] == '0);
    sgn    = a[31] ^ b[31];
    r      = '0;
    if (!is_div) begin
      if (a_nan)       r = {1'b1, QNAN, a_snan, 4'b0000};
      else if (a_zero) r = {1'b1, a, 5'b00000};
      else if (a[31])  r = {1'b1, QNAN, 5'b10000};
      else if (a_inf)  r = {1'b1, a, 5'b00000};
    end else begin
      if (a_nan || b_nan)
        r = {1'b1, QNAN, a_snan | b_snan, 4'b0000};
      else if ((a_zero && b_zero) || (a_inf && b_inf))
        r = {1'b1, QNAN, 5'b10000};
      else if (a_inf || b_zero)  // DZ only for finite / 0
        r = {1'b1, sgn, 8'hFF, 23'd0, 1'b0, b_zero && !a_inf, 3'b000};
      else if (a_zero || b_inf)
        r = {1'b1, sgn, 31'd0, 5'b00000};
    end
    return r;
  endfunction

  assign {byp_hit, byp_result, byp_fflags} = special_eval(head.lhs, head.rhs, head.is_div);
`else
  assign byp_hit    = 1'b0;
  assign byp_result = '0;
  assign byp_fflags = '0;
`endif

  // FIFO pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_op;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Launch/bypass decision, completion and flush handling.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    bypass    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst && !flush && !empty && slot_free) begin
          if (byp_hit) begin
            bypass = 1'b1;
          end else if (core_finished) begin
            launch    = 1'b1;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (core_finished) begin
          capture   = !flush;  // flush in the same cycle discards the result
          state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (core_finished) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Remember the launched op so core operands hold and the tag survives.
  always_ff @(posedge clk) begin
    if (rst)         issued <= '0;
    else if (launch) issued <= head;
  end

  assign core_req        = launch;
  assign core_lhs        = launch ? head.lhs    : issued.lhs;
  assign core_rhs        = launch ? head.rhs    : issued.rhs;
  assign core_is_divide  = launch ? head.is_div : issued.is_div;
  assign core_round_mode = launch ? head.rm     : issued.rm;

  // Output slot: capture from core or bypass, hold until writeback accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      io.out_valid  <= 1'b0;
      io.out_result <= '0;
      io.out_fflags <= '0;
      io.out_tag    <= '0;
    end else if (flush) begin
      io.out_valid <= 1'b0;
    end else if (capture) begin
      io.out_valid  <= 1'b1;
      io.out_result <= core_result;
      io.out_fflags <= core_fflags;
      io.out_tag    <= issued.tag;
    end else if (bypass) begin
      io.out_valid  <= 1'b1;
      io.out_result <= byp_result;
      io.out_fflags <= byp_fflags;
      io.out_tag    <= head.tag;
    end else if (io.out_valid && io.out_ready) begin
      io.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp32_divsqrt_issue_ctrl.sv
// Scoreboard bench for fp32_divsqrt_issue_ctrl with a behavioural core model
// (15-cycle divide, 14-cycle sqrt, result chosen by operands and rounding mode).
module tb_fp32_divsqrt_issue_ctrl;
  localparam int TW = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  frm;
  logic        flush;
  logic        core_req;
  logic [31:0] core_lhs, core_rhs;
  logic        core_is_divide;
  logic [2:0]  core_round_mode;
  logic        core_finished;
  logic [31:0] core_result;
  logic [4:0]  core_fflags;

  always #5 clk = ~clk;

  fp32_divsqrt_issue_ctrl_if #(.TAG_WIDTH(TW)) bus();

  fp32_divsqrt_issue_ctrl #(.TAG_WIDTH(TW), .QUEUE_DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .io              (bus.slave),
    .frm             (frm),
    .flush           (flush),
    .core_req        (core_req),
    .core_lhs        (core_lhs),
    .core_rhs        (core_rhs),
    .core_is_divide  (core_is_divide),
    .core_round_mode (core_round_mode),
    .core_finished   (core_finished),
    .core_result     (core_result),
    .core_fflags     (core_fflags)
  );

  // ---------------- core model ----------------
  function automatic logic [36:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic d, input logic [2:0] rm);
    if (d && a == 32'h40C00000 && b == 32'h40000000) return {32'h40400000, 5'h00};
    if (!d && a == 32'h40800000)                     return {32'h40000000, 5'h00};
    if (d && a == 32'h3F800000 && b == 32'h40400000)
      return {((rm == 3'd0 || rm == 3'd3 || rm == 3'd4) ? 32'h3EAAAAAB : 32'h3EAAAAAA), 5'h01};
    if (d && a == 32'h3F800000 && b == 32'h00000000) return {32'h7F800000, 5'h08};
    return {32'hDEADBEEF, 5'h1F};
  endfunction

  logic       cbusy;
  logic [4:0] ccnt;
  assign core_finished = !cbusy;

  always @(posedge clk) begin
    if (rst) begin
      cbusy <= 1'b0; ccnt <= '0; core_result <= '0; core_fflags <= '0;
    end else if (core_req) begin
      cbusy <= 1'b1;
      ccnt  <= core_is_divide ? 5'd14 : 5'd13;
      {core_result, core_fflags} <= core_fn(core_lhs, core_rhs, core_is_divide, core_round_mode);
    end else if (cbusy) begin
      ccnt <= ccnt - 5'd1;
      if (ccnt == 5'd1) cbusy <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [31:0] res; logic [4:0] fl; logic [TW-1:0] tag; } out_t;
  typedef struct { logic [31:0] lhs; logic [31:0] rhs; logic div; logic [2:0] rm; } lau_t;
  out_t out_q[$];
  lau_t lau_q[$];
  int   n_cmp = 0, n_err = 0, n_launch = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch monitor: every core_req must match the next expected launch.
  lau_t le;
  always @(negedge clk) begin
    if (!rst && core_req) begin
      n_launch++;
      n_cmp++;
      if (lau_q.size() == 0) begin
        n_err++;
        $display("FAIL launch: unexpected core_req lhs=%h rhs=%h", core_lhs, core_rhs);
      end else begin
        le = lau_q.pop_front();
        if ({core_lhs, core_rhs, core_is_divide, core_round_mode, core_finished} !==
            {le.lhs, le.rhs, le.div, le.rm, 1'b1}) begin
          n_err++;
          $display("FAIL launch: got %h/%h d=%b rm=%0d fin=%b expected %h/%h d=%b rm=%0d fin=1",
                   core_lhs, core_rhs, core_is_divide, core_round_mode, core_finished,
                   le.lhs, le.rhs, le.div, le.rm);
        end
      end
    end
  end

  // Result monitor: every accepted result must match the next expected one.
  out_t oe;
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      if (out_q.size() == 0) begin
        n_err++;
        $display("FAIL result: unexpected out tag=%h res=%h", bus.out_tag, bus.out_result);
      end else begin
        oe = out_q.pop_front();
        if ({bus.out_result, bus.out_fflags, bus.out_tag} !== {oe.res, oe.fl, oe.tag}) begin
          n_err++;
          $display("FAIL result: got res=%h fl=%h tag=%h expected res=%h fl=%h tag=%h",
                   bus.out_result, bus.out_fflags, bus.out_tag, oe.res, oe.fl, oe.tag);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic d,
                       input logic [2:0] rm, input logic [2:0] f, input logic [TW-1:0] tag,
                       input logic [2:0] exp_rm, input bit exp_launch, input bit exp_out,
                       input logic [31:0] res, input logic [4:0] fl);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_lhs = a; bus.in_rhs = b; bus.in_is_divide = d;
    bus.in_rm = rm; bus.in_tag = tag; frm = f;
    while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!bus.in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL issue_timeout: tag %h not accepted in 200 cycles", tag);
    end else begin
      if (exp_launch) lau_q.push_back('{lhs: a, rhs: b, div: d, rm: exp_rm});
      if (exp_out)    out_q.push_back('{res: res, fl: fl, tag: tag});
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((out_q.size() != 0 || lau_q.size() != 0 || !core_finished) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_pending", 64'(out_q.size() + lau_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  bit div0_launch;
  int base;

  initial begin
`ifdef FP_DIVSQRT_SPECIAL_BYPASS_EN
    div0_launch = 1'b0;
`else
    div0_launch = 1'b1;
`endif
    rst = 1'b1; flush = 1'b0; frm = 3'd0;
    bus.in_valid = 1'b0; bus.in_lhs = '0; bus.in_rhs = '0; bus.in_is_divide = 1'b0;
    bus.in_rm = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",   64'(bus.in_ready),   64'd1);
    chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
    chk("rst_out_result", 64'(bus.out_result), 64'd0);
    chk("rst_out_fflags", 64'(bus.out_fflags), 64'd0);
    chk("rst_out_tag",    64'(bus.out_tag),    64'd0);
    chk("rst_core_req",   64'(core_req),       64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic div / sqrt with dynamic rounding
    issue(32'h40C00000, 32'h40000000, 1'b1, 3'd0, 3'd0, 7'h11, 3'd0, 1, 1, 32'h40400000, 5'h00);
    wait_drain();
    issue(32'h40800000, 32'h0,        1'b0, 3'd7, 3'd0, 7'h12, 3'd0, 1, 1, 32'h40000000, 5'h00);
    wait_drain();

    // rounding-dependent results, queued back to back
    issue(32'h3F800000, 32'h40400000, 1'b1, 3'd0, 3'd2, 7'h13, 3'd0, 1, 1, 32'h3EAAAAAB, 5'h01);
    issue(32'h3F800000, 32'h40400000, 1'b1, 3'd1, 3'd0, 7'h14, 3'd1, 1, 1, 32'h3EAAAAAA, 5'h01);
    issue(32'h3F800000, 32'h40400000, 1'b1, 3'd7, 3'd1, 7'h15, 3'd1, 1, 1, 32'h3EAAAAAA, 5'h01);
    issue(32'h3F800000, 32'h40400000, 1'b1, 3'd7, 3'd3, 7'h16, 3'd3, 1, 1, 32'h3EAAAAAB, 5'h01);
    issue(32'h3F800000, 32'h40400000, 1'b1, 3'd5, 3'd0, 7'h17, 3'd5, 1, 1, 32'h3EAAAAAA, 5'h01);
    wait_drain();

    // divide by zero
    issue(32'h3F800000, 32'h00000000, 1'b1, 3'd0, 3'd0, 7'h18, 3'd0, div0_launch, 1,
          32'h7F800000, 5'h08);
    wait_drain();

    // backpressure: three ops with writeback stalled
    bus.out_ready = 1'b0;
    base = n_launch;
    issue(32'h40C00000, 32'h40000000, 1'b1, 3'd0, 3'd0, 7'h21, 3'd0, 1, 1, 32'h40400000, 5'h00);
    issue(32'h40800000, 32'h0,        1'b0, 3'd0, 3'd0, 7'h22, 3'd0, 1, 1, 32'h40000000, 5'h00);
    issue(32'h3F800000, 32'h40400000, 1'b1, 3'd1, 3'd0, 7'h23, 3'd1, 1, 1, 32'h3EAAAAAA, 5'h01);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (25) @(posedge clk);
    #1;
    chk("held_out_valid", 64'(bus.out_valid), 64'd1);
    chk("held_out_tag",   64'(bus.out_tag),   64'h21);
    chk("held_launches",  64'(n_launch - base), 64'd1);
    chk("held_in_ready",  64'(bus.in_ready),  64'd0);
    bus.out_ready = 1'b1;
    wait_drain();

    // flush mid-operation, with a push offered in the flush cycle
    issue(32'h40C00000, 32'h40000000, 1'b1, 3'd0, 3'd0, 7'h30, 3'd0, 1, 0, 32'h0, 5'h00);
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_lhs = 32'h3F800000; bus.in_rhs = 32'h40400000;
    bus.in_is_divide = 1'b1; bus.in_rm = 3'd0; bus.in_tag = 7'h31;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_fifo_empty", 64'(bus.in_ready),  64'd1);
    chk("flush_out_valid",  64'(bus.out_valid), 64'd0);
    chk("flush_core_busy",  64'(core_finished), 64'd0);
    issue(32'h40800000, 32'h0, 1'b0, 3'd0, 3'd0, 7'h32, 3'd0, 1, 1, 32'h40000000, 5'h00);
    wait_drain();
    repeat (20) @(posedge clk);
    #1;
    chk("final_out_valid", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
